// File: rtl/run_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : run_monitor
//  Purpose  : End-of-run monitor for the pipelined CPU simulation. Counts RUN
//             cycles, retired instructions and stall cycles. Ends the run on
//             core halt, on a cycle limit or on a no-retire watchdog. Latches
//             the return value and reports the reason the run ended.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             isHalt, ret_val    - core halt flag and return value
//             retire, stall      - per-cycle retire / stall indications
//             done, reason       - run finished (sticky), exit reason
//                                  (00 run, 01 halt, 10 timeout, 11 hung)
//             result             - ret_val captured at halt, else 0
//             cycle_count, retire_count, stall_count - saturating statistics
//  Revision : 1.0 - initial release
// ============================================================================
module run_monitor #(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CYCLE_LIMIT    = 500000,
    parameter int unsigned WATCHDOG_LIMIT = 1024,
    parameter bit          FINISH_ON_END  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  isHalt,
    input  logic [DATA_WIDTH-1:0] ret_val,
    input  logic                  retire,
    input  logic                  stall,
    output logic                  done,
    output logic [1:0]            reason,
    output logic [DATA_WIDTH-1:0] result,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    // Idle counter only needs to reach WATCHDOG_LIMIT; keep at least one bit
    // so the disabled configuration still elaborates.
    localparam int unsigned IDLE_W = (WATCHDOG_LIMIT == 0) ? 1 : $clog2(WATCHDOG_LIMIT + 1);

    localparam logic [CNT_WIDTH-1:0] C_CYCLE_LIMIT = CNT_WIDTH'(CYCLE_LIMIT);
    localparam logic [IDLE_W-1:0]    C_WD_LIMIT    = IDLE_W'(WATCHDOG_LIMIT);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [IDLE_W-1:0]    C_IDLE_ONE    = IDLE_W'(1);

    // Encoding doubles as the reason code.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        HALTED  = 2'b01,
        TIMEOUT = 2'b10,
        HUNG    = 2'b11
    } state_t;

    state_t              r_state;
    logic [IDLE_W-1:0]   r_idle_count;
    logic                w_timeout;
    logic                w_hang;

    assign w_timeout = (CYCLE_LIMIT != 0)    && (cycle_count  == C_CYCLE_LIMIT);
    assign w_hang    = (WATCHDOG_LIMIT != 0) && (r_idle_count == C_WD_LIMIT);

    assign reason = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            done         <= 1'b0;
            result       <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            stall_count  <= '0;
            r_idle_count <= '0;
        end else if (r_state == RUN) begin
            // Statistics include the exiting cycle.
            if (retire && (retire_count != '1))
                retire_count <= retire_count + C_CNT_ONE;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + C_CNT_ONE;

            if (retire)
                r_idle_count <= '0;
            else if (r_idle_count != '1)
                r_idle_count <= r_idle_count + C_IDLE_ONE;

            // A timeout exit leaves cycle_count at exactly CYCLE_LIMIT.
            if (!(w_timeout && !isHalt) && (cycle_count != '1))
                cycle_count <= cycle_count + C_CNT_ONE;

            // Exit priority: halt > timeout > hang.
            if (isHalt) begin
                r_state <= HALTED;
                done    <= 1'b1;
                result  <= ret_val;
            end else if (w_timeout) begin
                r_state <= TIMEOUT;
                done    <= 1'b1;
            end else if (w_hang) begin
                r_state <= HUNG;
                done    <= 1'b1;
            end
        end
        // Terminal states hold every output until reset.
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && (r_state == RUN) && (isHalt || w_timeout || w_hang)) begin
            if (isHalt)
                $display("Finished with << %0d >>", ret_val);
            else if (w_timeout)
                $display("ran for %0d cycles", CYCLE_LIMIT);
            else
                $display("hung after %0d idle cycles", WATCHDOG_LIMIT);
            if (FINISH_ON_END)
                $finish;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_run_monitor
//  Purpose  : Self-checking bench for run_monitor. Several instances with
//             different parameters share one stimulus bus; each scenario
//             checks the instance whose configuration it targets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        isHalt = 1'b0;
    logic [15:0] ret_val = '0;
    logic        retire = 1'b0;
    logic        stall = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default limits: halt, reset and table scenarios.
    logic main_done; logic [1:0] main_reason; logic [15:0] main_result;
    logic [31:0] main_cyc, main_ret, main_stl;
    // Timeout: CYCLE_LIMIT=20, watchdog off.
    logic to_done; logic [1:0] to_reason; logic [15:0] to_result;
    logic [31:0] to_cyc, to_ret, to_stl;
    // Watchdog: limit off, WATCHDOG_LIMIT=5.
    logic wd_done; logic [1:0] wd_reason; logic [15:0] wd_result;
    logic [31:0] wd_cyc, wd_ret, wd_stl;
    // Priority: both limits 8.
    logic pr_done; logic [1:0] pr_reason; logic [15:0] pr_result;
    logic [31:0] pr_cyc, pr_ret, pr_stl;
    // Saturation: 4-bit counters, limits off.
    logic sa_done; logic [1:0] sa_reason; logic [15:0] sa_result;
    logic [3:0] sa_cyc, sa_ret, sa_stl;
    // Random: 8-bit counters, CYCLE_LIMIT=40, WATCHDOG_LIMIT=6.
    logic rn_done; logic [1:0] rn_reason; logic [15:0] rn_result;
    logic [7:0] rn_cyc, rn_ret, rn_stl;

    run_monitor #(.CNT_WIDTH(32), .DATA_WIDTH(16), .CYCLE_LIMIT(500000), .WATCHDOG_LIMIT(1024), .FINISH_ON_END(1'b0)) u_main (
        .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val), .retire(retire), .stall(stall),
        .done(main_done), .reason(main_reason), .result(main_result),
        .cycle_count(main_cyc), .retire_count(main_ret), .stall_count(main_stl));

    run_monitor #(.CNT_WIDTH(32), .DATA_WIDTH(16), .CYCLE_LIMIT(20), .WATCHDOG_LIMIT(0), .FINISH_ON_END(1'b0)) u_to (
        .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val), .retire(retire), .stall(stall),
        .done(to_done), .reason(to_reason), .result(to_result),
        .cycle_count(to_cyc), .retire_count(to_ret), .stall_count(to_stl));

    run_monitor #(.CNT_WIDTH(32), .DATA_WIDTH(16), .CYCLE_LIMIT(0), .WATCHDOG_LIMIT(5), .FINISH_ON_END(1'b0)) u_wd (
        .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val), .retire(retire), .stall(stall),
        .done(wd_done), .reason(wd_reason), .result(wd_result),
        .cycle_count(wd_cyc), .retire_count(wd_ret), .stall_count(wd_stl));

    run_monitor #(.CNT_WIDTH(32), .DATA_WIDTH(16), .CYCLE_LIMIT(8), .WATCHDOG_LIMIT(8), .FINISH_ON_END(1'b0)) u_pr (
        .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val), .retire(retire), .stall(stall),
        .done(pr_done), .reason(pr_reason), .result(pr_result),
        .cycle_count(pr_cyc), .retire_count(pr_ret), .stall_count(pr_stl));

    run_monitor #(.CNT_WIDTH(4), .DATA_WIDTH(16), .CYCLE_LIMIT(0), .WATCHDOG_LIMIT(0), .FINISH_ON_END(1'b0)) u_sa (
        .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val), .retire(retire), .stall(stall),
        .done(sa_done), .reason(sa_reason), .result(sa_result),
        .cycle_count(sa_cyc), .retire_count(sa_ret), .stall_count(sa_stl));

    run_monitor #(.CNT_WIDTH(8), .DATA_WIDTH(16), .CYCLE_LIMIT(40), .WATCHDOG_LIMIT(6), .FINISH_ON_END(1'b0)) u_rn (
        .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val), .retire(retire), .stall(stall),
        .done(rn_done), .reason(rn_reason), .result(rn_result),
        .cycle_count(rn_cyc), .retire_count(rn_ret), .stall_count(rn_stl));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, sample 1ns after the edge.
    task automatic step(input logic r, input logic h, input logic [15:0] v,
                        input logic rt, input logic st);
        rst = r; isHalt = h; ret_val = v; retire = rt; stall = st;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, h;
        logic [15:0] v;
        logic        rt, st;
        logic        d;
        logic [1:0]  rs;
        logic [15:0] res;
        int          cyc, ret, stl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic h, logic [15:0] v, logic rt, logic st,
                                logic d, logic [1:0] rs, logic [15:0] res,
                                int cyc, int ret, int stl);
        vec_t x;
        x.r = r; x.h = h; x.v = v; x.rt = rt; x.st = st;
        x.d = d; x.rs = rs; x.res = res; x.cyc = cyc; x.ret = ret; x.stl = stl;
        return x;
    endfunction

    // Reference model state for the random instance (CNT 8, limits 40 / 6).
    int m_done, m_reason, m_result, m_cyc, m_ret, m_stl, m_idle;

    function automatic int sat8(int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic model_edge(input logic r, input logic h, input logic [15:0] v,
                              input logic rt, input logic st);
        int to_now, hang_now;
        if (r) begin
            m_done = 0; m_reason = 0; m_result = 0;
            m_cyc = 0; m_ret = 0; m_stl = 0; m_idle = 0;
        end else if (m_done == 0) begin
            to_now   = (m_cyc == 40);
            hang_now = (m_idle == 6);
            m_ret = sat8(m_ret + int'(rt));
            m_stl = sat8(m_stl + int'(st));
            if (h) begin
                m_done = 1; m_reason = 1; m_result = int'(v); m_cyc = sat8(m_cyc + 1);
            end else if (to_now != 0) begin
                m_done = 1; m_reason = 2;
            end else begin
                m_cyc = sat8(m_cyc + 1);
                if (hang_now != 0) begin
                    m_done = 1; m_reason = 3;
                end
            end
            m_idle = rt ? 0 : m_idle + 1;
        end
    endtask

    initial begin
        // ---------------- table-driven: reset, mid-run reset, halt ----------
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, k + 1, k + 1, k + 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, k + 1, k + 1, 0));
        vecs.push_back(mk(0, 1, 16'd42, 1, 0, 1, 2'b01, 16'd42, 11, 11, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 16'd99, 1, 1, 1, 2'b01, 16'd42, 11, 11, 0));
        vecs.push_back(mk(1, 1, 16'd5, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, k + 1, 0, k + 1));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].h, vecs[i].v, vecs[i].rt, vecs[i].st);
            chk($sformatf("vec%0d done", i),   64'(main_done),   64'(vecs[i].d));
            chk($sformatf("vec%0d reason", i), 64'(main_reason), 64'(vecs[i].rs));
            chk($sformatf("vec%0d result", i), 64'(main_result), 64'(vecs[i].res));
            chk($sformatf("vec%0d cycles", i), 64'(main_cyc),    64'(vecs[i].cyc));
            chk($sformatf("vec%0d retired", i), 64'(main_ret),   64'(vecs[i].ret));
            chk($sformatf("vec%0d stalls", i), 64'(main_stl),    64'(vecs[i].stl));
        end

        // ---------------- timeout at CYCLE_LIMIT=20 -------------------------
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 0);
        chk("to before edge 20 done", 64'(to_done), 64'd0);
        chk("to before edge 20 cycles", 64'(to_cyc), 64'd20);
        step(0, 0, 0, 1, 0);
        chk("to done", 64'(to_done), 64'd1);
        chk("to reason", 64'(to_reason), 64'd2);
        chk("to cycles", 64'(to_cyc), 64'd20);
        chk("to result", 64'(to_result), 64'd0);
        chk("to retired", 64'(to_ret), 64'd21);
        step(0, 1, 16'd3, 1, 1);
        chk("to frozen reason", 64'(to_reason), 64'd2);
        chk("to frozen retired", 64'(to_ret), 64'd21);

        // ---------------- watchdog at WATCHDOG_LIMIT=5 ----------------------
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
        chk("wd before exit done", 64'(wd_done), 64'd0);
        step(0, 0, 0, 0, 1);
        chk("wd done", 64'(wd_done), 64'd1);
        chk("wd reason", 64'(wd_reason), 64'd3);
        chk("wd retired", 64'(wd_ret), 64'd3);
        chk("wd stalls", 64'(wd_stl), 64'd6);
        chk("wd cycles", 64'(wd_cyc), 64'd9);

        // Retire on the would-be exit edge still exits.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("wd late retire reason", 64'(wd_reason), 64'd3);
        chk("wd late retire retired", 64'(wd_ret), 64'd1);

        // ---------------- priority: halt > timeout > hang -------------------
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 0);
        step(0, 1, 16'd7, 1, 0);
        chk("pri halt vs timeout reason", 64'(pr_reason), 64'd1);
        chk("pri halt vs timeout result", 64'(pr_result), 64'd7);
        chk("pri halt vs timeout cycles", 64'(pr_cyc), 64'd9);

        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 16'd7, 0, 0);
        chk("pri halt vs both reason", 64'(pr_reason), 64'd1);
        chk("pri halt vs both result", 64'(pr_result), 64'd7);

        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);
        step(0, 0, 16'd7, 0, 0);
        chk("pri timeout vs hang reason", 64'(pr_reason), 64'd2);
        chk("pri timeout vs hang result", 64'(pr_result), 64'd0);

        // ---------------- saturation with 4-bit counters --------------------
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) step(0, 0, 0, 1, 1);
        chk("sat cycles at 14", 64'(sa_cyc), 64'd14);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 1);
        chk("sat cycles", 64'(sa_cyc), 64'd15);
        chk("sat retired", 64'(sa_ret), 64'd15);
        chk("sat stalls", 64'(sa_stl), 64'd15);
        chk("sat done", 64'(sa_done), 64'd0);

        // ---------------- randomized against the reference model ------------
        for (int ep = 0; ep < 30; ep++) begin
            int p;
            p = int'($urandom_range(0, 4));
            model_edge(1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
            for (int e = 0; e < 60; e++) begin
                logic r, h, rt, st;
                logic [15:0] v;
                r  = ($urandom_range(0, 59) == 0);
                h  = ($urandom_range(0, 29) == 0);
                v  = 16'($urandom);
                rt = (int'($urandom_range(0, 3)) < p);
                st = $urandom_range(0, 1) == 1;
                model_edge(r, h, v, rt, st);
                step(r, h, v, rt, st);
                chk($sformatf("rnd ep%0d e%0d done", ep, e),    64'(rn_done),   64'(m_done));
                chk($sformatf("rnd ep%0d e%0d reason", ep, e),  64'(rn_reason), 64'(m_reason));
                chk($sformatf("rnd ep%0d e%0d result", ep, e),  64'(rn_result), 64'(m_result));
                chk($sformatf("rnd ep%0d e%0d cycles", ep, e),  64'(rn_cyc),    64'(m_cyc));
                chk($sformatf("rnd ep%0d e%0d retired", ep, e), 64'(rn_ret),    64'(m_ret));
                chk($sformatf("rnd ep%0d e%0d stalls", ep, e),  64'(rn_stl),    64'(m_stl));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
